axi_lite_csr_bank: RTL and testbench
====================================

Name: axi_lite_csr_bank

Overview:
Parametrised AXI4-Lite slave register bank. It is the next-generation CSR front end for the dot-product accelerator and its siblings.
- Adds generic register count, byte strobes, read-only status registers, proper OKAY/SLVERR responses on both channels, and per-register write-commit pulses.
- Sits between the AXI-Lite interconnect and accelerator control logic; exports all register contents flat.

Parameters:
ADDR_WIDTH, 32, AXI address width.
DATA_WIDTH, 32, data width; 32 or 64 only.
NUM_REGS, 8, number of registers; 1..256.
RO_MASK, 8'h20, bit i=1 makes register i read-only (value sourced from ro_in).
RESET_VALUES, all zero, NUM_REGS*DATA_WIDTH flat vector; slice i is reset value of register i.
SC_MASK, 32'h1, self-clearing bits of register 0 (used only with optional feature).

Ports:
ACLK  in  1  clock.
ARESETN  in  1  reset.
AWADDR  in  ADDR_WIDTH  write address.
AWVALID  in  1 / AWREADY  out  1  write-address handshake.
WDATA  in  DATA_WIDTH  write data.
WSTRB  in  DATA_WIDTH/8  byte-lane enables.
WVALID  in  1 / WREADY  out  1  write-data handshake.
BRESP  out  2 / BVALID  out  1 / BREADY  in  1  write response.
ARADDR  in  ADDR_WIDTH  read address.
ARVALID  in  1 / ARREADY  out  1  read-address handshake.
RDATA  out  DATA_WIDTH / RRESP  out  2 / RVALID  out  1 / RREADY  in  1  read data.
reg_out  out  NUM_REGS*DATA_WIDTH  current value of every register (RO slices mirror ro_in).
ro_in  in  NUM_REGS*DATA_WIDTH  live values for read-only registers; other slices ignored.
wr_pulse  out  NUM_REGS  one-cycle pulse per register on successful write commit.

Behaviour:
- Reset: ARESETN is asynchronous, active-low; clock is ACLK. In reset:
  - AWREADY, WREADY, BVALID, ARREADY, RVALID = 0.
  - BRESP, RRESP = 2'b00; RDATA = 0; wr_pulse = 0.
  - Registers load RESET_VALUES.
  - Reset mid-transaction aborts it; no partial write lands.
- Decode:
  - index = addr[LSB +: IDXW], with LSB = log2(DATA_WIDTH/8) and IDXW = clog2(NUM_REGS).
  - Address bits below LSB are ignored.
  - Address is invalid if index >= NUM_REGS or any bit above LSB+IDXW is set.
- Write FSM, states W_ACCEPT, W_COMMIT, W_RESP:
  - W_ACCEPT:
    - AWREADY = !aw_held and WREADY = !w_held (combinational from state/flags).
    - AW and W are accepted independently, in either order or in the same cycle; each is latched into a holding register.
    - When both are held (or both complete this edge), go to W_COMMIT.
  - W_COMMIT (one cycle):
    - If the address is valid and not RO: byte lane k of the register updates where WSTRB[k]=1; wr_pulse[index]=1 for that cycle; BRESP=OKAY.
    - If the address is invalid or the target is RO: no state change, BRESP=SLVERR (2'b10).
    - BVALID goes to 1; go to W_RESP.
  - W_RESP: BVALID held with BRESP stable until BREADY; then BVALID=0, flags cleared, return to W_ACCEPT.
  - Latency: handshake at edge N → register and BVALID updated at edge N+1.
  - WSTRB=0 with a valid address: OKAY, no change, wr_pulse still fires.
- Read FSM, states R_ACCEPT, R_DATA:
  - R_ACCEPT: ARREADY=1.
  - On handshake, RDATA/RRESP are registered at the same edge, RVALID=1, go to R_DATA.
    - RO register → ro_in slice.
    - Writable register → register value.
    - Invalid address → RDATA=0, RRESP=SLVERR.
  - R_DATA: hold RDATA/RRESP stable until RREADY; then RVALID=0, return to R_ACCEPT.
  - Read latency: 1 cycle.
- Simultaneous events:
  - Read and write FSMs are fully independent.
  - A read sampled on the same edge as a W_COMMIT to the same register returns the pre-write value.

Optional Feature:
AXIL_CSR_SELF_CLEAR_EN
- Defined: bits of register 0 set in SC_MASK clear one cycle after any write commit that sets them (start-bit behaviour). Reads after that cycle return 0 in those bits.
- Undefined: SC_MASK is ignored and written bits persist.

Decomposition:
- Package axil_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - write_state_t and read_state_t enums.
  - Width helper for clog2.
- One sub-module, axil_csr_decode (combinational): addr → index, valid, is_ro. Instantiated twice, once for AW and once for AR.

Test Plan:
- Default reset values: reset, then read 0x0..0x1C → RESET_VALUES slices, RRESP=OKAY. Read 0x20 → RDATA=0, RRESP=SLVERR.
- Write ordering: W before AW, then AW before W, then same-cycle. Write 0xA5A5_0000 to 0x04 → BRESP=OKAY; wr_pulse[1] high for exactly one cycle; reg_out slice 1 = 0xA5A5_0000 one edge after the last handshake.
- Byte strobes: reg 2 = 0x1122_3344; write 0xFFFF_FFFF with WSTRB=4'b0101 → reads back 0x11FF_33FF.
- Read-only register: write 0x14 (RO) → SLVERR, reg unchanged, no wr_pulse. Drive ro_in slice 5 = 0xCAFE_0001 → read 0x14 returns 0xCAFE_0001.
- Backpressure and reset: hold BREADY=0 and RREADY=0 for 10 cycles → BVALID/RVALID, BRESP/RDATA stable. Assert ARESETN low mid-W_RESP → BVALID=0 and registers return to RESET_VALUES.
- AXIL_CSR_SELF_CLEAR_EN: with the macro defined, write 0x1 to 0x00 → bit0 reads 1 for one cycle, then 0. Without the macro → bit0 stays 1.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite CSR bank.
// Response codes, FSM state encodings and an index-width helper.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_ACCEPT,
        W_COMMIT,
        W_RESP
    } write_state_t;

    typedef enum logic {
        R_ACCEPT,
        R_DATA
    } read_state_t;

    // Register index width; a single-register bank still needs one bit
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axil_csr_decode.sv
// Combinational CSR address decoder: byte address to register index,
// validity and read-only flag.
module axil_csr_decode
    import axil_pkg::*;
#(
    parameter int                ADDR_WIDTH = 32,
    parameter int                DATA_WIDTH = 32,
    parameter int                NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK  = NUM_REGS'('h20),
    localparam int               LSB        = $clog2(DATA_WIDTH / 8),
    localparam int               IDXW       = idx_width(NUM_REGS)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [IDXW-1:0]       index,
    output logic                  valid,
    output logic                  is_ro
);

    localparam int TOP = LSB + IDXW;

    logic [ADDR_WIDTH-1:0] hi_bits;
    logic                  lsb_unused;

    assign index      = addr[LSB +: IDXW];
    assign hi_bits    = addr >> TOP;
    assign lsb_unused = ^addr[LSB-1:0];

    // Range check and read-only lookup for the decoded index
    always_comb begin
        valid = (hi_bits == '0) && (int'(index) < NUM_REGS);
        is_ro = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (valid && index == IDXW'(i)) begin
                is_ro = RO_MASK[i];
            end
        end
    end

endmodule

// File: rtl/axi_lite_csr_bank.sv
// AXI4-Lite slave register bank with byte strobes, read-only status
// registers and write-commit pulses. Option: AXIL_CSR_SELF_CLEAR_EN.
module axi_lite_csr_bank
    import axil_pkg::*;
#(
    parameter int                              ADDR_WIDTH   = 32,
    parameter int                              DATA_WIDTH   = 32,
    parameter int                              NUM_REGS     = 8,
    parameter logic [NUM_REGS-1:0]             RO_MASK      = NUM_REGS'('h20),
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VALUES = '0,
    parameter logic [DATA_WIDTH-1:0]           SC_MASK      = DATA_WIDTH'(1)
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int IDXW = idx_width(NUM_REGS);

    write_state_t wstate;
    read_state_t  rstate;

    logic                  rst_done;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NB-1:0]         wstrb_q;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic [IDXW-1:0]       aw_index;
    logic                  aw_ok;
    logic                  aw_ro;
    logic [IDXW-1:0]       ar_index;
    logic                  ar_ok;
    logic                  ar_ro;
    logic [DATA_WIDTH-1:0] rd_word;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;

`ifndef AXIL_CSR_SELF_CLEAR_EN
    logic sc_unused;
    assign sc_unused = ^SC_MASK;
`endif

    axil_csr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RO_MASK    (RO_MASK)
    ) u_aw_dec (
        .addr  (aw_addr_q),
        .index (aw_index),
        .valid (aw_ok),
        .is_ro (aw_ro)
    );

    axil_csr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RO_MASK    (RO_MASK)
    ) u_ar_dec (
        .addr  (ARADDR),
        .index (ar_index),
        .valid (ar_ok),
        .is_ro (ar_ro)
    );

    assign AWREADY = rst_done && (wstate == W_ACCEPT) && !aw_held;
    assign WREADY  = rst_done && (wstate == W_ACCEPT) && !w_held;
    assign ARREADY = rst_done && (rstate == R_ACCEPT);

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // Keeps ready outputs low while reset is asserted
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // Flat register view; read-only slices come straight from ro_in
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_WIDTH +: DATA_WIDTH] =
                RO_MASK[i] ? ro_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
        end
    end

    // Read mux over the flat view so RO registers return live values
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_index == IDXW'(i)) begin
                rd_word = reg_out[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Write channel FSM, holding registers and register storage
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wstate    <= W_ACCEPT;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            BVALID    <= 1'b0;
            BRESP     <= RESP_OKAY;
            wr_pulse  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            wr_pulse <= '0;
`ifdef AXIL_CSR_SELF_CLEAR_EN
            regs[0] <= regs[0] & ~SC_MASK;
`endif
            unique case (wstate)
                W_ACCEPT: begin
                    if (aw_hs) begin
                        aw_held   <= 1'b1;
                        aw_addr_q <= AWADDR;
                    end
                    if (w_hs) begin
                        w_held  <= 1'b1;
                        wdata_q <= WDATA;
                        wstrb_q <= WSTRB;
                    end
                    if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                        wstate <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    if (aw_ok && !aw_ro) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (aw_index == IDXW'(i)) begin
                                wr_pulse[i] <= 1'b1;
                                for (int k = 0; k < NB; k++) begin
                                    if (wstrb_q[k]) begin
                                        regs[i][8*k +: 8] <= wdata_q[8*k +: 8];
                                    end
                                end
                            end
                        end
                        BRESP <= RESP_OKAY;
                    end else begin
                        BRESP <= RESP_SLVERR;
                    end
                    BVALID <= 1'b1;
                    wstate <= W_RESP;
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        wstate  <= W_ACCEPT;
                    end
                end
                default: begin
                    wstate <= W_ACCEPT;
                end
            endcase
        end
    end

    // Read channel FSM with registered data and response
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rstate <= R_ACCEPT;
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= RESP_OKAY;
        end else begin
            unique case (rstate)
                R_ACCEPT: begin
                    if (ar_hs) begin
                        RVALID <= 1'b1;
                        rstate <= R_DATA;
                        if (ar_ok) begin
                            RDATA <= rd_word;
                            RRESP <= RESP_OKAY;
                        end else begin
                            RDATA <= '0;
                            RRESP <= RESP_SLVERR;
                        end
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        RVALID <= 1'b0;
                        rstate <= R_ACCEPT;
                    end
                end
                default: begin
                    rstate <= R_ACCEPT;
                end
            endcase
        end
    end

    logic ro_unused;
    assign ro_unused = ar_ro;

endmodule

// File: tb/tb_axi_lite_csr_bank.sv
// Directed self-checking bench for axi_lite_csr_bank.
// Expected self-clear behaviour follows AXIL_CSR_SELF_CLEAR_EN.
module tb_axi_lite_csr_bank;

    localparam logic [255:0] RV = {
        32'h7070_0007, 32'h6060_0006, 32'h5050_0005, 32'h4040_0004,
        32'h3030_0003, 32'h2020_0002, 32'h1010_0001, 32'h0000_0000
    };
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic [31:0]  AWADDR = '0;
    logic         AWVALID = 1'b0;
    logic         AWREADY;
    logic [31:0]  WDATA = '0;
    logic [3:0]   WSTRB = '0;
    logic         WVALID = 1'b0;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY = 1'b0;
    logic [31:0]  ARADDR = '0;
    logic         ARVALID = 1'b0;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY = 1'b0;
    logic [255:0] reg_out;
    logic [255:0] ro_in = '1;
    logic [7:0]   wr_pulse;

    int checks = 0;
    int errors = 0;
    int pulse_cnt [8] = '{default: 0};
    int pulse_total = 0;
    logic [31:0] er [8];

    axi_lite_csr_bank #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .NUM_REGS     (8),
        .RO_MASK      (8'h20),
        .RESET_VALUES (RV),
        .SC_MASK      (32'h1)
    ) dut (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .AWADDR   (AWADDR),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .ARADDR   (ARADDR),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .reg_out  (reg_out),
        .ro_in    (ro_in),
        .wr_pulse (wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) begin
        for (int i = 0; i < 8; i++) begin
            if (wr_pulse[i]) begin
                pulse_cnt[i]++;
                pulse_total++;
            end
        end
    end

    function automatic logic [255:0] pack();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = er[i];
        return v;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        AWADDR = a;
        AWVALID = 1'b1;
        while (!AWREADY && n < 20) begin
            @(posedge ACLK); #1; n++;
        end
        if (n >= 20) check("aw_timeout", 0, 1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        WDATA = d;
        WSTRB = s;
        WVALID = 1'b1;
        while (!WREADY && n < 20) begin
            @(posedge ACLK); #1; n++;
        end
        if (n >= 20) check("w_timeout", 0, 1);
        @(posedge ACLK); #1;
        WVALID = 1'b0;
    endtask

    task automatic send_both(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        int n = 0;
        AWADDR = a;
        WDATA = d;
        WSTRB = s;
        AWVALID = 1'b1;
        WVALID = 1'b1;
        while (!(AWREADY && WREADY) && n < 20) begin
            @(posedge ACLK); #1; n++;
        end
        if (n >= 20) check("aww_timeout", 0, 1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        WVALID = 1'b0;
    endtask

    // order: 0 = W first, 1 = AW first, 2 = same cycle
    task automatic write_check(input string tag, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s,
                               input int order, input logic [1:0] exp_resp,
                               input int pidx, input logic [255:0] old_v,
                               input logic [255:0] new_v);
        int p0;
        int t0;
        int n;
        p0 = (pidx >= 0) ? pulse_cnt[pidx] : 0;
        t0 = pulse_total;
        case (order)
            0: begin send_w(d, s); send_aw(a); end
            1: begin send_aw(a); send_w(d, s); end
            default: send_both(a, d, s);
        endcase
        check({tag, "_bvalid_pre"}, BVALID, 0);
        check({tag, "_regs_pre"}, reg_out, old_v);
        @(posedge ACLK); #1;
        check({tag, "_bvalid"}, BVALID, 1);
        check({tag, "_bresp"}, BRESP, exp_resp);
        check({tag, "_regs_post"}, reg_out, new_v);
        n = 0;
        while (!BVALID && n < 20) begin
            @(posedge ACLK); #1; n++;
        end
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        check({tag, "_bvalid_clr"}, BVALID, 0);
        if (pidx >= 0) check({tag, "_pulse"}, pulse_cnt[pidx] - p0, 1);
        check({tag, "_pulse_total"}, pulse_total - t0, (pidx >= 0) ? 1 : 0);
    endtask

    task automatic read_check(input string tag, input logic [31:0] a,
                              input logic [31:0] exp_d,
                              input logic [1:0] exp_r);
        int n = 0;
        ARADDR = a;
        ARVALID = 1'b1;
        while (!ARREADY && n < 20) begin
            @(posedge ACLK); #1; n++;
        end
        if (n >= 20) check({tag, "_ar_timeout"}, 0, 1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        check({tag, "_rvalid"}, RVALID, 1);
        check({tag, "_rdata"}, RDATA, exp_d);
        check({tag, "_rresp"}, RRESP, exp_r);
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] old_v;
        logic [31:0]  snap_d;
        logic [1:0]   snap_b;
        logic         stable;

        // Reset state
        ro_in[5*32 +: 32] = 32'hDEAD_0005;
        for (int i = 0; i < 8; i++) er[i] = RV[i*32 +: 32];
        er[5] = 32'hDEAD_0005;
        #12;
        check("rst_ready_valid",
              {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b0);
        check("rst_resp", {BRESP, RRESP}, 4'b0);
        check("rst_rdata", RDATA, 0);
        check("rst_pulse", wr_pulse, 0);
        check("rst_regs", reg_out, pack());
        ARESETN = 1'b1;
        @(posedge ACLK); #1;

        // Reset values and decode boundaries
        for (int i = 0; i < 8; i++) begin
            read_check($sformatf("rd_reset%0d", i), 32'(i * 4), er[i], OKAY);
        end
        read_check("rd_0x20", 32'h20, 32'h0, SLVERR);
        read_check("rd_0x40", 32'h40, 32'h0, SLVERR);
        read_check("rd_0x05", 32'h05, 32'h1010_0001, OKAY);

        // Write ordering
        old_v = pack(); er[1] = 32'hA5A5_0000;
        write_check("wr_w_first", 32'h04, 32'hA5A5_0000, 4'hF, 0,
                    OKAY, 1, old_v, pack());
        old_v = pack(); er[1] = 32'h0000_5A5A;
        write_check("wr_aw_first", 32'h04, 32'h0000_5A5A, 4'hF, 1,
                    OKAY, 1, old_v, pack());
        old_v = pack(); er[1] = 32'hA5A5_0000;
        write_check("wr_same", 32'h04, 32'hA5A5_0000, 4'hF, 2,
                    OKAY, 1, old_v, pack());
        read_check("rd_reg1", 32'h04, 32'hA5A5_0000, OKAY);

        // Byte strobes
        old_v = pack(); er[2] = 32'h1122_3344;
        write_check("wr_reg2", 32'h08, 32'h1122_3344, 4'hF, 2,
                    OKAY, 2, old_v, pack());
        old_v = pack(); er[2] = 32'h11FF_33FF;
        write_check("wr_strb", 32'h08, 32'hFFFF_FFFF, 4'b0101, 2,
                    OKAY, 2, old_v, pack());
        read_check("rd_strb", 32'h08, 32'h11FF_33FF, OKAY);

        // Zero strobe: OKAY, no change, pulse still fires
        old_v = pack();
        write_check("wr_strb0", 32'h0C, 32'hFFFF_FFFF, 4'h0, 2,
                    OKAY, 3, old_v, pack());

        // Read-only and invalid targets
        old_v = pack();
        write_check("wr_ro", 32'h14, 32'h1234_5678, 4'hF, 2,
                    SLVERR, -1, old_v, pack());
        old_v = pack();
        write_check("wr_inval", 32'h20, 32'h1234_5678, 4'hF, 0,
                    SLVERR, -1, old_v, pack());
        ro_in[5*32 +: 32] = 32'hCAFE_0001;
        er[5] = 32'hCAFE_0001;
        read_check("rd_ro", 32'h14, 32'hCAFE_0001, OKAY);
        check("ro_mirror", reg_out, pack());

        // Read on the commit edge returns the pre-write value
        AWADDR = 32'h0C; WDATA = 32'hBEEF_0003; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = 32'h0C; ARVALID = 1'b1;
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        check("coll_rvalid", RVALID, 1);
        check("coll_rdata", RDATA, 32'h3030_0003);
        check("coll_bvalid", BVALID, 1);
        check("coll_bresp", BRESP, OKAY);
        BREADY = 1'b1; RREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0; RREADY = 1'b0;
        check("coll_clr", {BVALID, RVALID}, 2'b00);
        er[3] = 32'hBEEF_0003;
        check("coll_regs", reg_out, pack());
        read_check("rd_coll", 32'h0C, 32'hBEEF_0003, OKAY);

        // Backpressure on both channels
        AWADDR = 32'h10; WDATA = 32'h4444_AAAA; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = 32'h04; ARVALID = 1'b1;
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        snap_d = RDATA;
        snap_b = BRESP;
        check("bp_rdata", RDATA, 32'hA5A5_0000);
        check("bp_bresp", BRESP, OKAY);
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge ACLK); #1;
            if (!BVALID || !RVALID || BRESP !== snap_b || RDATA !== snap_d)
                stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        er[4] = 32'h4444_AAAA;
        check("bp_regs", reg_out, pack());

        // Reset while the write response is pending
        ARESETN = 1'b0;
        #1;
        check("rst_mid_valid", {BVALID, RVALID, AWREADY, WREADY, ARREADY},
              5'b0);
        check("rst_mid_pulse", wr_pulse, 0);
        for (int i = 0; i < 8; i++) er[i] = RV[i*32 +: 32];
        er[5] = 32'hCAFE_0001;
        check("rst_mid_regs", reg_out, pack());
        #2;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        read_check("rd_after_rst", 32'h04, 32'h1010_0001, OKAY);

        // Start bit in register 0
        old_v = pack(); er[0] = 32'h0000_0001;
        write_check("wr_sc", 32'h00, 32'h0000_0001, 4'hF, 2,
                    OKAY, 0, old_v, pack());
`ifdef AXIL_CSR_SELF_CLEAR_EN
        er[0] = 32'h0000_0000;
`endif
        check("sc_regs", reg_out, pack());
        read_check("rd_sc", 32'h00, er[0], OKAY);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
